// File: rtl/if_pkg.sv
// Shared fetch/decode definitions.
//   state_t       : assembler word-position state (first word / awaiting immediate)
//   PC_W, WORD_W  : default program-counter and instruction-word widths
//   LONG_BIT      : bit of a first word that marks a two-word instruction;
//                   the decoder keys off the same bit.
package if_pkg;
  localparam int PC_W     = 32;
  localparam int WORD_W   = 16;
  localparam int LONG_BIT = 15;

  typedef enum logic {S_FIRST, S_SECOND} state_t;
endpackage

// File: rtl/if_id_assembler.sv
// IF->ID instruction assembler.
// Accepts 16-bit fetch words, pairs a long opcode word with the immediate word
// that follows it, and presents whole instructions to decode in a one-deep
// valid/ready output slot. in_ready doubles as the fetch enable.
// Ports:
//   clk, rst                 clock; async active-high reset
//   flush                    discard pending first word and the output slot
//   in_valid/in_ready        fetch-side handshake; in_word, in_pc payload
//   out_valid/out_ready      decode-side handshake
//   out_instr/out_imm/out_pc opcode word, immediate word (0 if short), pc
//   out_long                 instruction was two words
//   seq_err                  one-cycle pulse: immediate pc was not opcode pc+1
module if_id_assembler #(
  parameter int PC_W     = if_pkg::PC_W,
  parameter int WORD_W   = if_pkg::WORD_W,
  parameter int LONG_BIT = if_pkg::LONG_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_imm,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_long,
  output logic              seq_err
);

  if_pkg::state_t    state;
  logic [WORD_W-1:0] pend_instr;
  logic [PC_W-1:0]   pend_pc;

  logic accept, consume, pair_ok, pc_break, is_long;

  // Combinational out_ready -> in_ready path keeps one word per cycle
  // flowing while decode is draining the slot.
  assign in_ready = ~flush & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;
  assign is_long  = in_word[LONG_BIT];
  // pc+1 is computed at PC_W bits so the all-ones pc pairs with pc 0.
  assign pair_ok  = (state == if_pkg::S_SECOND) && (in_pc == pend_pc + PC_W'(1));
  assign pc_break = (state == if_pkg::S_SECOND) && !pair_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= if_pkg::S_FIRST;
      pend_instr <= '0;
      pend_pc    <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_imm    <= '0;
      out_pc     <= '0;
      out_long   <= 1'b0;
      seq_err    <= 1'b0;
    end else if (flush) begin
      // in_ready is low here, so nothing was accepted; a consume is void.
      state      <= if_pkg::S_FIRST;
      pend_instr <= '0;
      pend_pc    <= '0;
      out_valid  <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      if (consume) out_valid <= 1'b0;
      if (accept) begin
        if (pair_ok) begin
          out_valid <= 1'b1;
          out_instr <= pend_instr;
          out_imm   <= in_word;
          out_pc    <= pend_pc;
          out_long  <= 1'b1;
          state     <= if_pkg::S_FIRST;
        end else begin
          // Broken pair: drop the pending word and treat this one as a fresh
          // first word.
          seq_err <= pc_break;
          if (is_long) begin
            pend_instr <= in_word;
            pend_pc    <= in_pc;
            state      <= if_pkg::S_SECOND;
          end else begin
            out_valid <= 1'b1;
            out_instr <= in_word;
            out_imm   <= '0;
            out_pc    <= in_pc;
            out_long  <= 1'b0;
            state     <= if_pkg::S_FIRST;
          end
        end
      end
    end
  end

endmodule
